// File: rtl/c1355_sec_pkg.sv
// rtl/c1355_sec_pkg.sv - shared widths and column function for the c1355 SEC code
package c1355_sec_pkg;

   localparam int DATA_W  = 32;
   localparam int CHECK_W = 8;

   // Column of data bit i: low nibble selects the byte, high nibble the bit within it
   function automatic logic [CHECK_W-1:0] h_col(input logic [4:0] i);
      logic [1:0] b;
      logic [2:0] k;
      logic [3:0] lo;
      logic [3:0] hi;
      b  = i[4:3];
      k  = i[2:0];
      lo = 4'b0001 << b;
      if (!k[2]) begin
         hi = 4'b0001 << k[1:0];
      end else begin
         hi = ~(4'b0001 << k[1:0]);
      end
      return {hi, lo};
   endfunction

endpackage

// File: rtl/c1355_sec_syndrome.sv
// rtl/c1355_sec_syndrome.sv - combinational parity tree producing the syndrome
module c1355_sec_syndrome
   import c1355_sec_pkg::*;
(
   input  logic [DATA_W-1:0]  data_in,
   input  logic [CHECK_W-1:0] check_in,
   output logic [CHECK_W-1:0] syndrome
);

   logic [CHECK_W-1:0] col;

   // Fold every data bit into the check bits its column touches
   always_comb begin
      syndrome = check_in;
      col      = '0;
      for (int i = 0; i < DATA_W; i++) begin
         col = h_col(5'(i));
         for (int j = 0; j < CHECK_W; j++) begin
            if (col[j]) begin
               syndrome[j] = syndrome[j] ^ data_in[i];
            end
         end
      end
   end

endmodule

// File: rtl/c1355_sec.sv
// rtl/c1355_sec.sv - registered 32-bit single-error-correcting decoder
module c1355_sec
   import c1355_sec_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   data_in,
   input  logic [CHECK_W-1:0]  check_in,
   input  logic                correct_en,
   output logic                out_valid,
   output logic [DATA_W-1:0]   data_out,
   output logic [CHECK_W-1:0]  syndrome,
   output logic                err_corrected,
   output logic                err_uncorr
);

   logic [CHECK_W-1:0] syn;
   logic [DATA_W-1:0]  data_fix;
   logic               col_hit;
   logic               chk_hit;

   logic               out_valid_d, out_valid_q;
   logic [DATA_W-1:0]  data_d, data_q;
   logic [CHECK_W-1:0] syn_d, syn_q;
   logic               corr_d, corr_q;
   logic               uncorr_d, uncorr_q;

   c1355_sec_syndrome u_syndrome (
      .data_in  (data_in),
      .check_in (check_in),
      .syndrome (syn)
   );

   // Match the syndrome against every data column and flip the hit bit
   always_comb begin
      data_fix = data_in;
      col_hit  = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         if (syn == h_col(5'(i))) begin
            data_fix[i] = ~data_in[i];
            col_hit     = 1'b1;
         end
      end
      chk_hit = (syn != '0) && ((syn & (syn - 8'd1)) == '0);
   end

   // Next-state: load a new result only on valid input, otherwise hold
   always_comb begin
      out_valid_d = in_valid;
      data_d      = data_q;
      syn_d       = syn_q;
      corr_d      = corr_q;
      uncorr_d    = uncorr_q;
      if (in_valid) begin
         syn_d    = syn;
         data_d   = correct_en ? data_fix : data_in;
         corr_d   = correct_en & (col_hit | chk_hit);
         uncorr_d = correct_en & (syn != '0) & ~col_hit & ~chk_hit;
      end
   end

   // Single output register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         data_q      <= '0;
         syn_q       <= '0;
         corr_q      <= 1'b0;
         uncorr_q    <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         data_q      <= data_d;
         syn_q       <= syn_d;
         corr_q      <= corr_d;
         uncorr_q    <= uncorr_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign data_out      = data_q;
   assign syndrome      = syn_q;
   assign err_corrected = corr_q;
   assign err_uncorr    = uncorr_q;

endmodule

// File: tb/tb_c1355_sec.sv
// tb/tb_c1355_sec.sv - self-checking bench for c1355_sec
module tb_c1355_sec;
   import c1355_sec_pkg::*;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  syn;
      logic        ec;
      logic        eu;
   } res_t;

   typedef struct {
      logic [31:0] d;
      logic [7:0]  c;
      logic        e;
      res_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] data_in = '0;
   logic [7:0]  check_in = '0;
   logic        correct_en = 1'b0;
   logic        out_valid;
   logic [31:0] data_out;
   logic [7:0]  syndrome;
   logic        err_corrected;
   logic        err_uncorr;

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];
   res_t last_exp;

   c1355_sec dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .data_in       (data_in),
      .check_in      (check_in),
      .correct_en    (correct_en),
      .out_valid     (out_valid),
      .data_out      (data_out),
      .syndrome      (syndrome),
      .err_corrected (err_corrected),
      .err_uncorr    (err_uncorr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic res_t model(input logic [31:0] d, input logic [7:0] c, input logic e);
      res_t r;
      logic [7:0] s;
      logic [7:0] col;
      int hit;
      int ones;
      s = c;
      for (int i = 0; i < 32; i++) begin
         col = h_col(5'(i));
         if (d[i]) s = s ^ col;
      end
      hit = -1;
      for (int i = 0; i < 32; i++) begin
         if (h_col(5'(i)) == s) hit = i;
      end
      ones = 0;
      for (int j = 0; j < 8; j++) ones += int'(s[j]);
      r.syn  = s;
      r.data = d;
      r.ec   = 1'b0;
      r.eu   = 1'b0;
      if (e && s != 8'h00) begin
         if (hit >= 0) begin
            r.data[hit] = ~d[hit];
            r.ec = 1'b1;
         end else if (ones == 1) begin
            r.ec = 1'b1;
         end else begin
            r.eu = 1'b1;
         end
      end
      return r;
   endfunction

   task automatic cmp_res(input string tag, input res_t r);
      chk({tag, ".data_out"}, data_out, r.data);
      chk({tag, ".syndrome"}, 32'(syndrome), 32'(r.syn));
      chk({tag, ".err_corrected"}, 32'(err_corrected), 32'(r.ec));
      chk({tag, ".err_uncorr"}, 32'(err_uncorr), 32'(r.eu));
   endtask

   // Drive at the negedge, sample 1 time unit after the following posedge
   task automatic apply(input logic v, input logic [31:0] d, input logic [7:0] c,
                        input logic e, input string tag);
      res_t r;
      in_valid   = v;
      data_in    = d;
      check_in   = c;
      correct_en = e;
      if (v) exp_q.push_back(model(d, c, e));
      @(posedge clk);
      #1;
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            chk({tag, ".unexpected_output"}, 32'd1, 32'd0);
         end else begin
            r = exp_q.pop_front();
            cmp_res(tag, r);
            last_exp = r;
         end
      end else begin
         cmp_res({tag, ".hold"}, last_exp);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   vec_t vecs[6];
   res_t zero_res;

   initial begin
      logic [31:0] d;
      logic [7:0]  c;
      int          mode;
      int          b;
      res_t        base;

      zero_res = '{data: 32'h0, syn: 8'h00, ec: 1'b0, eu: 1'b0};
      last_exp = zero_res;
      vecs[0] = '{d: 32'hFFFFFFFF, c: 8'h00, e: 1'b1, exp: '{data: 32'hFFFFFFFF, syn: 8'h00, ec: 1'b0, eu: 1'b0}};
      vecs[1] = '{d: 32'h00000001, c: 8'h00, e: 1'b1, exp: '{data: 32'h00000000, syn: 8'h11, ec: 1'b1, eu: 1'b0}};
      vecs[2] = '{d: 32'h7FFFFFFF, c: 8'h00, e: 1'b1, exp: '{data: 32'hFFFFFFFF, syn: 8'h78, ec: 1'b1, eu: 1'b0}};
      vecs[3] = '{d: 32'h00000000, c: 8'h04, e: 1'b1, exp: '{data: 32'h00000000, syn: 8'h04, ec: 1'b1, eu: 1'b0}};
      vecs[4] = '{d: 32'h00000003, c: 8'h00, e: 1'b1, exp: '{data: 32'h00000003, syn: 8'h30, ec: 1'b0, eu: 1'b1}};
      vecs[5] = '{d: 32'h00000001, c: 8'h00, e: 1'b0, exp: '{data: 32'h00000001, syn: 8'h11, ec: 1'b0, eu: 1'b0}};

      // Reset state while rst_n is held low
      #12;
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      cmp_res("reset", zero_res);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table: hand-computed expectations, result one edge later
      for (int i = 0; i < 6; i++) begin
         in_valid   = 1'b1;
         data_in    = vecs[i].d;
         check_in   = vecs[i].c;
         correct_en = vecs[i].e;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'd1);
         cmp_res($sformatf("vec%0d", i), vecs[i].exp);
         last_exp = vecs[i].exp;
         @(negedge clk);
      end

      // Idle cycle: valid drops, result registers hold
      apply(1'b0, 32'hDEADBEEF, 8'h55, 1'b1, "idle_hold");

      // Asynchronous reset mid-stream clears outputs before any clock edge
      apply(1'b1, 32'h00000003, 8'h00, 1'b1, "pre_reset");
      in_valid = 1'b1;
      data_in  = 32'h00000001;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset.out_valid", 32'(out_valid), 32'd0);
      cmp_res("async_reset", zero_res);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      last_exp = zero_res;
      apply(1'b1, 32'h80000000, 8'h00, 1'b1, "post_reset");

      // Random sweep: clean codewords, single-bit faults and random words
      for (int n = 0; n < 10000; n++) begin
         d    = $urandom;
         mode = $urandom_range(0, 3);
         base = model(d, 8'h00, 1'b1);
         c    = base.syn;
         if (mode == 1) begin
            b = $urandom_range(0, 39);
            if (b < 32) d[b] = ~d[b];
            else c[b-32] = ~c[b-32];
         end else if (mode == 2) begin
            c = 8'($urandom);
         end else if (mode == 3) begin
            b = $urandom_range(0, 31);
            d[b] = ~d[b];
            b = $urandom_range(0, 31);
            d[b] = ~d[b];
         end
         apply(($urandom_range(0, 3) != 0), d, c, ($urandom_range(0, 7) != 0), "rand");
      end

      chk("scoreboard.drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
